// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam int WDOG_W    = 8;
   localparam logic [WDOG_W-1:0] WDOG_LIMIT = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for pipeline performance statistics.
// Only exists when PIPE_PERF_CNT_EN is defined, so a default build carries
// no counter logic at all.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // count events, holding at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (!rstn)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// data-memory handshake FSM (IDLE/WAIT/DONE) with a sticky watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN enables stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [REG_IDX_W-1:0] IFID_rs1,
   input  logic [REG_IDX_W-1:0] IFID_rs2,
   input  logic                 IFID_use_rs1,
   input  logic                 IFID_use_rs2,
   input  logic                 IDEX_MemRead,
   input  logic [REG_IDX_W-1:0] IDEX_rd,
   input  logic                 EX_branch_taken,
   input  logic                 EXMEM_MemRead,
   input  logic                 EXMEM_MemWrite,
   input  logic                 dmem_ready,
   output logic                 dmem_req,
   output logic                 PC_stall,
   output logic                 IFID_stall,
   output logic                 IDEX_stall,
   output logic                 EXMEM_stall,
   output logic                 IFID_flush,
   output logic                 IDEX_flush,
   output logic                 MEMWB_flush,
   output logic [1:0]           mem_state,
   output logic                 mem_timeout,
   output logic [31:0]          cnt_stall,
   output logic [31:0]          cnt_flush
);

   mem_state_t        r_state;
   mem_state_t        w_state_nxt;
   logic              r_dmem_req;
   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout;
   logic              w_access;
   logic              w_mem_stall;
   logic              w_load_use;

   assign w_access = EXMEM_MemRead | EXMEM_MemWrite;

   // x0 is never a real producer, so a load to it cannot create a hazard
   assign w_load_use = IDEX_MemRead && (IDEX_rd != '0) &&
                       ((IFID_use_rs1 && (IDEX_rd == IFID_rs1)) ||
                        (IFID_use_rs2 && (IDEX_rd == IFID_rs2)));

   // next state plus all stall/flush outputs; a memory stall freezes EX, so
   // branch and load-use actions wait until DONE where they still hold
   always_comb begin
      w_state_nxt = IDLE;
      w_mem_stall = 1'b0;
      PC_stall    = 1'b0;
      IFID_stall  = 1'b0;
      IDEX_stall  = 1'b0;
      EXMEM_stall = 1'b0;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      MEMWB_flush = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               w_state_nxt = WAIT;
               w_mem_stall = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            w_mem_stall = 1'b1;
            w_state_nxt = dmem_ready ? DONE : WAIT;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      if (w_mem_stall) begin
         PC_stall    = 1'b1;
         IFID_stall  = 1'b1;
         IDEX_stall  = 1'b1;
         EXMEM_stall = 1'b1;
         MEMWB_flush = 1'b1;
      end else if (EX_branch_taken) begin
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
      end else if (w_load_use) begin
         PC_stall    = 1'b1;
         IFID_stall  = 1'b1;
         IDEX_flush  = 1'b1;
      end
   end

   // state and request flops; request mirrors "next state is WAIT" so a
   // reset mid-access drops it immediately and DONE never sees it high
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_dmem_req <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_dmem_req <= (w_state_nxt == WAIT);
      end
   end

   // watchdog: counts WAIT cycles, flags a sticky timeout when it hits the limit
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == WAIT) begin
         if (r_wdog != WDOG_LIMIT)
            r_wdog <= r_wdog + WDOG_W'(1);
         if (r_wdog == (WDOG_LIMIT - WDOG_W'(1)))
            r_timeout <= 1'b1;
      end else begin
         r_wdog <= '0;
      end
   end

   assign dmem_req    = r_dmem_req;
   assign mem_state   = r_state;
   assign mem_timeout = r_timeout;

`ifdef PIPE_PERF_CNT_EN
   pipe_perf_cnt #(.W(32)) u_cnt_stall (
      .clk   (clk),
      .rstn  (rstn),
      .i_inc (PC_stall),
      .o_cnt (cnt_stall)
   );

   pipe_perf_cnt #(.W(32)) u_cnt_flush (
      .clk   (clk),
      .rstn  (rstn),
      .i_inc (IDEX_flush),
      .o_cnt (cnt_flush)
   );
`else
   assign cnt_stall = '0;
   assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, each cycle's expected outputs come from a behavioural model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
   logic       IFID_use_rs1, IFID_use_rs2, IDEX_MemRead, EX_branch_taken;
   logic       EXMEM_MemRead, EXMEM_MemWrite, dmem_ready;
   logic       dmem_req, PC_stall, IFID_stall, IDEX_stall, EXMEM_stall;
   logic       IFID_flush, IDEX_flush, MEMWB_flush, mem_timeout;
   logic [1:0] mem_state;
   logic [31:0] cnt_stall, cnt_flush;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rstn(rstn),
      .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
      .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
      .EX_branch_taken(EX_branch_taken),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
      .dmem_ready(dmem_ready), .dmem_req(dmem_req),
      .PC_stall(PC_stall), .IFID_stall(IFID_stall),
      .IDEX_stall(IDEX_stall), .EXMEM_stall(EXMEM_stall),
      .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
      .MEMWB_flush(MEMWB_flush), .mem_state(mem_state),
      .mem_timeout(mem_timeout), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
   );

   typedef struct {
      bit     pc_stall, ifid_stall, idex_stall, exmem_stall;
      bit     ifid_flush, idex_flush, memwb_flush, dmem_req, mem_to;
      int     st;
      longint cs, cf;
      bit     seg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   seg_stall = 0;
   int   seg_req = 0;

   // reference model state: phase 0=idle 1=waiting 2=done
   int     m_phase = 0;
   int     m_waits = 0;
   bit     m_to = 0;
   longint m_cs = 0, m_cf = 0;
   localparam longint CNT_MAX = 64'hFFFF_FFFF;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic zero_in();
      IFID_rs1 = 0; IFID_rs2 = 0; IDEX_rd = 0;
      IFID_use_rs1 = 0; IFID_use_rs2 = 0; IDEX_MemRead = 0;
      EX_branch_taken = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
      dmem_ready = 0;
   endtask

   // predict this cycle's outputs from current inputs, then advance the model
   task automatic cycle(input bit seg);
      exp_t e;
      bit access, stall, hazard;
      access = EXMEM_MemRead || EXMEM_MemWrite;
      stall  = (m_phase == 1) || (m_phase == 0 && access);
      hazard = IDEX_MemRead && (IDEX_rd != 0) &&
               ((IFID_use_rs1 && IFID_rs1 == IDEX_rd) || (IFID_use_rs2 && IFID_rs2 == IDEX_rd));
      e = '{default: 0};
      if (stall) begin
         e.pc_stall = 1; e.ifid_stall = 1; e.idex_stall = 1;
         e.exmem_stall = 1; e.memwb_flush = 1;
      end else if (EX_branch_taken) begin
         e.ifid_flush = 1; e.idex_flush = 1;
      end else if (hazard) begin
         e.pc_stall = 1; e.ifid_stall = 1; e.idex_flush = 1;
      end
      e.dmem_req = (m_phase == 1);
      e.st       = m_phase;
      e.mem_to   = m_to;
`ifdef PIPE_PERF_CNT_EN
      e.cs = m_cs; e.cf = m_cf;
`endif
      e.seg = seg;
      sb.push_back(e);
      if (!rstn) begin
         m_phase = 0; m_waits = 0; m_to = 0; m_cs = 0; m_cf = 0;
      end else begin
         if (e.pc_stall && m_cs < CNT_MAX) m_cs++;
         if (e.idex_flush && m_cf < CNT_MAX) m_cf++;
         case (m_phase)
            0: if (access) m_phase = 1;
            1: begin
               m_waits++;
               if (m_waits >= 255) m_to = 1;
               if (dmem_ready) m_phase = 2;
            end
            default: m_phase = 0;
         endcase
         if (m_phase != 1) m_waits = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      zero_in();
      rstn = 0;
      cycle(0);
      rstn = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
      #1;
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);
   endtask

   // monitor: pops one expectation per cycle and compares every output
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("PC_stall",    64'(PC_stall),    64'(e.pc_stall));
         chk("IFID_stall",  64'(IFID_stall),  64'(e.ifid_stall));
         chk("IDEX_stall",  64'(IDEX_stall),  64'(e.idex_stall));
         chk("EXMEM_stall", 64'(EXMEM_stall), 64'(e.exmem_stall));
         chk("IFID_flush",  64'(IFID_flush),  64'(e.ifid_flush));
         chk("IDEX_flush",  64'(IDEX_flush),  64'(e.idex_flush));
         chk("MEMWB_flush", 64'(MEMWB_flush), 64'(e.memwb_flush));
         chk("dmem_req",    64'(dmem_req),    64'(e.dmem_req));
         chk("mem_state",   64'(mem_state),   64'(e.st));
         chk("mem_timeout", 64'(mem_timeout), 64'(e.mem_to));
         chk("cnt_stall",   64'(cnt_stall),   64'(e.cs));
         chk("cnt_flush",   64'(cnt_flush),   64'(e.cf));
         if (e.seg) begin
            seg_stall += int'(PC_stall);
            seg_req   += int'(dmem_req);
         end
      end
   end

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL global_timeout: bench did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      zero_in();
      rstn = 0;
      @(posedge clk); #1;
      // first edge put the DUT into reset; model starts at reset state
      do_reset();

      // load-use hazard on rs2, then the same with rd=0
      IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs2 = 5; IFID_use_rs2 = 1; IFID_rs1 = 7;
      cycle(0);
      IDEX_rd = 0;
      cycle(0);
      // branch plus load-use in one cycle
      IDEX_rd = 5; EX_branch_taken = 1;
      cycle(0);
      zero_in();
      cycle(0);

      // memory access, ready on the third WAIT cycle
      do_reset();
      seg_stall = 0; seg_req = 0;
      EXMEM_MemRead = 1;
      cycle(1);            // IDLE detects access
      cycle(1);            // WAIT 1
      cycle(1);            // WAIT 2
      dmem_ready = 1;
      cycle(1);            // WAIT 3
      dmem_ready = 0;
      cycle(1);            // DONE
      EXMEM_MemRead = 0;
      cycle(1);            // IDLE
      drain();
      chk("seq_stall_cycles", 64'(seg_stall), 64'd4);
      chk("seq_dmem_req_cycles", 64'(seg_req), 64'd3);
`ifdef PIPE_PERF_CNT_EN
      chk("seq_cnt_stall", 64'(cnt_stall), 64'd4);
`endif

      // branch held through a memory stall: flush only in DONE
      do_reset();
      EXMEM_MemWrite = 1; EX_branch_taken = 1;
      cycle(0);
      dmem_ready = 1;
      cycle(0);
      dmem_ready = 0;
      cycle(0);
      zero_in();
      cycle(0);

      // watchdog: ready never comes, then reset clears everything
      do_reset();
      EXMEM_MemWrite = 1;
      for (int i = 0; i < 300; i++) cycle(0);
      drain();
      chk("watchdog_timeout_set", 64'(mem_timeout), 64'd1);
      rstn = 0;
      cycle(0);
      rstn = 1;
      zero_in();
      cycle(0);

      // random traffic, including resets that land mid-access
      for (int n = 0; n < 2500; n++) begin
         rstn            = ($urandom_range(0, 49) != 0);
         IFID_rs1        = 5'($urandom_range(0, 3));
         IFID_rs2        = 5'($urandom_range(0, 3));
         IDEX_rd         = 5'($urandom_range(0, 3));
         IFID_use_rs1    = 1'($urandom_range(0, 1));
         IFID_use_rs2    = 1'($urandom_range(0, 1));
         IDEX_MemRead    = 1'($urandom_range(0, 1));
         EX_branch_taken = ($urandom_range(0, 3) == 0);
         EXMEM_MemRead   = ($urandom_range(0, 3) == 0);
         EXMEM_MemWrite  = ($urandom_range(0, 5) == 0);
         dmem_ready      = ($urandom_range(0, 2) == 0);
         cycle(0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
